// File: rtl/uc_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module   : uc_multiciclo_if
// Brief    : Opcode/handshake inputs and datapath control outputs of the
//            multi-cycle control unit.
// Revision : 1.0
// ============================================================================
interface uc_multiciclo_if #(
    parameter int ALU_W       = 3,
    parameter int STACK_DEPTH = 4
);
    localparam int OPW  = ALU_W + 3;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [OPW-1:0]   Opcode;
    logic             zero;
    logic             i_ready;
    logic             ir_load;
    logic             pc_en;
    logic             s_inc;
    logic             s_ret;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic [ALU_W-1:0] AluOp;
    logic             push;
    logic             pop;
    logic [SP_W-1:0]  sp;
    logic             halted;
    logic             fault;

    modport master (
        output Opcode, zero, i_ready,
        input  ir_load, pc_en, s_inc, s_ret, s_inm, we, wez, AluOp,
        input  push, pop, sp, halted, fault
    );

    modport slave (
        input  Opcode, zero, i_ready,
        output ir_load, pc_en, s_inc, s_ret, s_inm, we, wez, AluOp,
        output push, pop, sp, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : uc_multiciclo
// Brief    : FETCH/DECODE/EXEC control unit with return stack, HALT and FAULT.
// Revision : 1.0
// ============================================================================
module uc_multiciclo #(
    parameter int ALU_W       = 3,
    parameter int STACK_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    uc_multiciclo_if.slave  bus
);
    localparam int OPW  = ALU_W + 3;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] c_depth = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALT   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OPW-1:0]   r_op;
    logic [SP_W-1:0]  r_sp;

    logic             w_ir_load;
    logic             w_pc_en;
    logic             w_s_inc;
    logic             w_s_ret;
    logic             w_s_inm;
    logic             w_we;
    logic             w_wez;
    logic [ALU_W-1:0] w_alu_op;
    logic             w_push;
    logic             w_pop;
    logic             w_halted;
    logic             w_fault;
    logic [3:0]       w_top;
    logic [1:0]       w_low;

    assign w_top = r_op[OPW-1:OPW-4];
    assign w_low = r_op[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
            r_op    <= '0;
            r_sp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE) begin
                r_op <= bus.Opcode;
            end
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_pc_en     = 1'b0;
        w_s_inc     = 1'b0;
        w_s_ret     = 1'b0;
        w_s_inm     = 1'b0;
        w_we        = 1'b0;
        w_wez       = 1'b0;
        w_alu_op    = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_halted    = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_ir_load = bus.i_ready;
                if (bus.i_ready) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                w_pc_en     = 1'b1;
                if (!r_op[OPW-1]) begin
                    w_s_inc  = 1'b1;
                    w_we     = 1'b1;
                    w_wez    = 1'b1;
                    w_alu_op = r_op[OPW-2:2];
                end else if (w_top == 4'b1100) begin
                    case (w_low)
                        2'b00:   w_s_inc = 1'b0;
                        2'b01:   w_s_inc = ~bus.zero;
                        2'b10:   w_s_inc = bus.zero;
                        default: w_s_inc = 1'b1;
                    endcase
                end else if (w_top == 4'b1101) begin
                    case (w_low)
                        2'b00: begin
                            if (r_sp < c_depth) begin
                                w_push = 1'b1;
                            end else begin
                                w_pc_en     = 1'b0;
                                w_state_nxt = ST_FAULT;
                            end
                        end
                        2'b01: begin
                            if (r_sp != '0) begin
                                w_pop   = 1'b1;
                                w_s_ret = 1'b1;
                            end else begin
                                w_pc_en     = 1'b0;
                                w_state_nxt = ST_FAULT;
                            end
                        end
                        2'b10: w_s_inc = 1'b1;
                        default: begin
                            w_pc_en     = 1'b0;
                            w_state_nxt = ST_HALT;
                        end
                    endcase
                end else begin
                    w_s_inc  = 1'b1;
                    w_s_inm  = 1'b1;
                    w_we     = 1'b1;
                    w_wez    = 1'b1;
                    w_alu_op = r_op[OPW-2:2];
                end
            end
            ST_HALT:  w_halted = 1'b1;
            ST_FAULT: w_fault  = 1'b1;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    // State already sits in FETCH during reset; gating keeps ir_load quiet too.
    assign bus.ir_load = w_ir_load & reset_n;
    assign bus.pc_en   = w_pc_en;
    assign bus.s_inc   = w_s_inc;
    assign bus.s_ret   = w_s_ret;
    assign bus.s_inm   = w_s_inm;
    assign bus.we      = w_we;
    assign bus.wez     = w_wez;
    assign bus.AluOp   = w_alu_op;
    assign bus.push    = w_push;
    assign bus.pop     = w_pop;
    assign bus.sp      = r_sp;
    assign bus.halted  = w_halted;
    assign bus.fault   = w_fault;
endmodule
`default_nettype wire
